matmul_feeder: RTL

MATMUL_FEEDER -- requirements
Module: matmul_feeder

---
 rtl/matmul_feeder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/matmul_feeder.sv
// rtl/matmul_feeder.sv - operand skew feeder and result capture for a 2x2 output-stationary systolic array
module matmul_feeder #(
    parameter int DATA_W       = 8,
    parameter int ACC_W        = 18,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] a11,
    input  logic signed [DATA_W-1:0] a12,
    input  logic signed [DATA_W-1:0] a21,
    input  logic signed [DATA_W-1:0] a22,
    input  logic signed [DATA_W-1:0] b11,
    input  logic signed [DATA_W-1:0] b12,
    input  logic signed [DATA_W-1:0] b21,
    input  logic signed [DATA_W-1:0] b22,
    output logic signed [DATA_W-1:0] a1,
    output logic signed [DATA_W-1:0] a2,
    output logic signed [DATA_W-1:0] b1,
    output logic signed [DATA_W-1:0] b2,
    output logic                     arr_clr,
    input  logic signed [ACC_W-1:0]  c11_in,
    input  logic signed [ACC_W-1:0]  c12_in,
    input  logic signed [ACC_W-1:0]  c21_in,
    input  logic signed [ACC_W-1:0]  c22_in,
    output logic signed [ACC_W-1:0]  r11,
    output logic signed [ACC_W-1:0]  r12,
    output logic signed [ACC_W-1:0]  r21,
    output logic signed [ACC_W-1:0]  r22,
    output logic                     busy,
    output logic                     done
);

    // The last zero-feed cycle is spent in CAPT, so DRAIN holds DRAIN_CYCLES-1 cycles.
    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        CAPT  = 3'd4
    } state_t;

    state_t                   state;
    logic [1:0]               phase;
    logic [CNT_W-1:0]         drain_cnt;
    logic signed [DATA_W-1:0] la11, la12, la21, la22;
    logic signed [DATA_W-1:0] lb11, lb12, lb21, lb22;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            phase     <= '0;
            drain_cnt <= '0;
            a1        <= '0;
            a2        <= '0;
            b1        <= '0;
            b2        <= '0;
            r11       <= '0;
            r12       <= '0;
            r21       <= '0;
            r22       <= '0;
            done      <= 1'b0;
            arr_clr   <= 1'b1;
            la11      <= '0;
            la12      <= '0;
            la21      <= '0;
            la22      <= '0;
            lb11      <= '0;
            lb12      <= '0;
            lb21      <= '0;
            lb22      <= '0;
        end else begin
            // Streams idle at zero unless a feed phase overrides them below.
            a1      <= '0;
            a2      <= '0;
            b1      <= '0;
            b2      <= '0;
            done    <= 1'b0;
            arr_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        la11    <= a11;
                        la12    <= a12;
                        la21    <= a21;
                        la22    <= a22;
                        lb11    <= b11;
                        lb12    <= b12;
                        lb21    <= b21;
                        lb22    <= b22;
                        arr_clr <= 1'b1;
                        state   <= CLR;
                    end
                end
                CLR: begin
                    a1    <= la11;
                    b1    <= lb11;
                    phase <= 2'd0;
                    state <= FEED;
                end
                FEED: begin
                    // phase names the values currently on the streams; load the next set.
                    case (phase)
                        2'd0: begin
                            a1    <= la12;
                            b1    <= lb21;
                            a2    <= la21;
                            b2    <= lb12;
                            phase <= 2'd1;
                        end
                        2'd1: begin
                            a2    <= la22;
                            b2    <= lb22;
                            phase <= 2'd2;
                        end
                        default: begin
                            phase <= 2'd0;
                            if (DRAIN_CYCLES < 2) begin
                                state <= CAPT;
                            end else begin
                                drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
                                state     <= DRAIN;
                            end
                        end
                    endcase
                end
                DRAIN: begin
                    if (drain_cnt == CNT_W'(1)) begin
                        drain_cnt <= '0;
                        state     <= CAPT;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                CAPT: begin
                    r11   <= c11_in;
                    r12   <= c12_in;
                    r21   <= c21_in;
                    r22   <= c22_in;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
